// File: rtl/svd_cordic_seq.sv
`default_nettype none
// ============================================================================
// Module   : svd_cordic_seq
// Brief    : Micro-op sequencer driving the shared CORDIC core of the 2x2
//            Jacobi SVD: two vectoring ops, angle combine, four rotations.
//            Optional macro SVD_SEQ_SCALE_EN appends a gain-scale op (op6).
// Revision : 1.0 - initial release
// ============================================================================
module svd_cordic_seq #(
   parameter  int ITER = 12,
   localparam int SHW  = $clog2(ITER)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           ack,
   output logic           busy,
   output logic           ready,
   output logic [2:0]     op_idx,
   output logic [1:0]     cordic_mode,
   output logic           cordic_load,
   output logic           cordic_en,
   output logic [SHW-1:0] cordic_shift,
   output logic           wb_en,
   output logic           ang_calc
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ITER  = 3'd2,
      S_WB    = 3'd3,
      S_ANGLE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [1:0]     c_MODE_ROT   = 2'b00;
   localparam logic [1:0]     c_MODE_VEC   = 2'b01;
   localparam logic [SHW-1:0] c_LAST_SHIFT = SHW'(ITER - 1);
`ifdef SVD_SEQ_SCALE_EN
   localparam logic [1:0]     c_MODE_SCALE = 2'b10;
   localparam logic [2:0]     c_LAST_OP    = 3'd6;
`else
   localparam logic [2:0]     c_LAST_OP    = 3'd5;
`endif

   state_t r_state;

   // Ops 0/1 extract the sum/difference angles; the rest rotate (or scale).
   function automatic logic [1:0] f_mode(input logic [2:0] op);
      logic [1:0] m;
      m = c_MODE_ROT;
      if (op < 3'd2)
         m = c_MODE_VEC;
`ifdef SVD_SEQ_SCALE_EN
      else if (op == 3'd6)
         m = c_MODE_SCALE;
`endif
      return m;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         busy         <= 1'b0;
         ready        <= 1'b0;
         op_idx       <= 3'd0;
         cordic_mode  <= c_MODE_ROT;
         cordic_load  <= 1'b0;
         cordic_en    <= 1'b0;
         cordic_shift <= '0;
         wb_en        <= 1'b0;
         ang_calc     <= 1'b0;
      end else begin
         cordic_load <= 1'b0;
         cordic_en   <= 1'b0;
         wb_en       <= 1'b0;
         ang_calc    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_LOAD;
                  op_idx      <= 3'd0;
                  cordic_mode <= c_MODE_VEC;
                  cordic_load <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            S_LOAD: begin
               r_state      <= S_ITER;
               cordic_shift <= '0;
               cordic_en    <= 1'b1;
            end
            S_ITER: begin
               if (cordic_shift == c_LAST_SHIFT) begin
                  r_state      <= S_WB;
                  cordic_shift <= '0;
                  wb_en        <= 1'b1;
               end else begin
                  cordic_shift <= cordic_shift + 1'b1;
                  cordic_en    <= 1'b1;
               end
            end
            S_WB: begin
               if (op_idx == 3'd1) begin
                  r_state  <= S_ANGLE;
                  ang_calc <= 1'b1;
               end else if (op_idx == c_LAST_OP) begin
                  r_state     <= S_DONE;
                  busy        <= 1'b0;
                  ready       <= 1'b1;
                  cordic_mode <= c_MODE_ROT;
               end else begin
                  r_state     <= S_LOAD;
                  op_idx      <= op_idx + 3'd1;
                  cordic_mode <= f_mode(op_idx + 3'd1);
                  cordic_load <= 1'b1;
               end
            end
            S_ANGLE: begin
               r_state     <= S_LOAD;
               op_idx      <= 3'd2;
               cordic_mode <= c_MODE_ROT;
               cordic_load <= 1'b1;
            end
            S_DONE: begin
               // A new run takes priority over a readout acknowledge.
               if (start) begin
                  r_state     <= S_LOAD;
                  op_idx      <= 3'd0;
                  cordic_mode <= c_MODE_VEC;
                  cordic_load <= 1'b1;
                  busy        <= 1'b1;
                  ready       <= 1'b0;
               end else if (ack) begin
                  r_state <= S_IDLE;
                  op_idx  <= 3'd0;
                  ready   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               ready   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_svd_cordic_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_svd_cordic_seq
// Brief    : Scoreboard bench for svd_cordic_seq (ITER=12 and ITER=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_svd_cordic_seq;

`ifdef SVD_SEQ_SCALE_EN
   localparam int NOPS = 7;
`else
   localparam int NOPS = 6;
`endif
   localparam int ITER  = 12;
   localparam int LAT   = NOPS * (ITER + 2) + 1;
   localparam int ITER4 = 4;
   localparam int LAT4  = NOPS * (ITER4 + 2) + 1;

   logic       clk, rst, start, ack;
   logic       busy, ready, cordic_load, cordic_en, wb_en, ang_calc;
   logic [2:0] op_idx;
   logic [1:0] cordic_mode;
   logic [3:0] cordic_shift;

   logic       start4, ack4;
   logic       busy4, ready4, load4, en4, wb4, ang4;
   logic [2:0] op_idx4;
   logic [1:0] mode4;
   logic [1:0] shift4;

   svd_cordic_seq #(.ITER(ITER)) dut (
      .clk(clk), .rst(rst), .start(start), .ack(ack), .busy(busy), .ready(ready),
      .op_idx(op_idx), .cordic_mode(cordic_mode), .cordic_load(cordic_load),
      .cordic_en(cordic_en), .cordic_shift(cordic_shift), .wb_en(wb_en), .ang_calc(ang_calc)
   );

   svd_cordic_seq #(.ITER(ITER4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .ack(ack4), .busy(busy4), .ready(ready4),
      .op_idx(op_idx4), .cordic_mode(mode4), .cordic_load(load4),
      .cordic_en(en4), .cordic_shift(shift4), .wb_en(wb4), .ang_calc(ang4)
   );

   typedef struct {
      int rdy_cyc;
      int n_en;
      int n_load;
      int n_wb;
      int n_ang;
   } exp_t;
   exp_t sb[$];

   int compared   = 0;
   int mismatched = 0;
   int pcyc       = 0;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_mode(input int op);
      if (op < 2) return 1;
      if (op == 6) return 2;
      return 0;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) pcyc <= pcyc + 1;

   // Monitor: per-cycle protocol checks plus scoreboard pop on ready rising.
   int m_en, m_load, m_wb, m_ang, m_shift;
   bit prev_ready, prev_wb;
   always @(negedge clk) begin
      if (!rst) begin
         m_en = 0; m_load = 0; m_wb = 0; m_ang = 0; m_shift = 0;
         prev_ready = 1'b0; prev_wb = 1'b0;
      end else begin
         check("one_strobe", int'(cordic_load) + int'(cordic_en) + int'(wb_en) + int'(ang_calc),
               int'(busy));
         if (cordic_load) begin
            check("load_op_idx", int'(op_idx), m_load);
            check("load_mode", int'(cordic_mode), exp_mode(m_load));
            m_load++;
            m_shift = 0;
         end
         if (cordic_en) begin
            check("shift_seq", int'(cordic_shift), m_shift);
            m_shift++;
            m_en++;
         end
         if (wb_en) begin
            check("wb_after_iter", m_shift, ITER);
            m_wb++;
         end
         if (ang_calc) begin
            check("ang_op_idx", int'(op_idx), 1);
            check("ang_after_wb", int'(prev_wb), 1);
            m_ang++;
         end
         if (ready && !prev_ready) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_ready: got ready at cycle %0d expected none", pcyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("ready_cycle", pcyc, e.rdy_cyc);
               check("n_cordic_en", m_en, e.n_en);
               check("n_cordic_load", m_load, e.n_load);
               check("n_wb_en", m_wb, e.n_wb);
               check("n_ang_calc", m_ang, e.n_ang);
            end
            m_en = 0; m_load = 0; m_wb = 0; m_ang = 0;
         end
         prev_ready = ready;
         prev_wb    = wb_en;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at the cycle start is driven; the run begins at the following edge.
   task automatic issue();
      exp_t e;
      e.rdy_cyc = pcyc + 1 + LAT;
      e.n_en    = NOPS * ITER;
      e.n_load  = NOPS;
      e.n_wb    = NOPS;
      e.n_ang   = 1;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!ready && n < 300) begin
         tick();
         n++;
      end
      check(name, int'(ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, e4, l4, s4, nwb;
      rst = 1'b1; start = 1'bx; ack = 1'bx; start4 = 1'bx; ack4 = 1'bx;
      // T1: asynchronous reset between clock edges
      #3 rst = 1'b0;
      #1;
      check("t1_rst_outs", int'({busy, ready, op_idx, cordic_mode, cordic_load, cordic_en,
                                 cordic_shift, wb_en, ang_calc}), 0);
      check("t1_rst_outs4", int'({busy4, ready4, op_idx4, mode4, load4, en4, shift4, wb4, ang4}), 0);
      start = 1'b0; ack = 1'b0; start4 = 1'b0; ack4 = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick(); tick();
      check("idle_busy", int'(busy), 0);

      // T2: single-cycle start pulse
      start = 1'b1; issue(); tick(); start = 1'b0;
      wait_ready("t2_ready");
      repeat (3) tick();
      check("done_hold", int'(ready), 1);

      // T4a: ack returns to IDLE
      ack = 1'b1; tick(); ack = 1'b0;
      check("ack_ready", int'(ready), 0);
      check("ack_idle_busy", int'(busy), 0);

      // T3: start held high and stray ack pulses while busy
      start = 1'b1; issue();
      for (int i = 0; i < 20; i++) begin
         ack = (i % 7 == 3);
         tick();
      end
      start = 1'b0; ack = 1'b0;
      wait_ready("t3_ready");

      // T4b: start and ack together in DONE -> new run
      start = 1'b1; ack = 1'b1; issue(); tick(); start = 1'b0; ack = 1'b0;
      check("rerun_load", int'(cordic_load), 1);
      check("rerun_op", int'(op_idx), 0);
      check("rerun_ready", int'(ready), 0);
      check("rerun_busy", int'(busy), 1);
      wait_ready("t4_ready");
      ack = 1'b1; tick(); ack = 1'b0;

      // T5: reset during op3 iteration 5
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (!(op_idx == 3'd3 && cordic_en && cordic_shift == 4'd5) && n < 200) begin
         tick();
         n++;
      end
      check("t5_reach", int'(op_idx == 3'd3 && cordic_en && cordic_shift == 4'd5), 1);
      #2 rst = 1'b0;
      #1;
      check("t5_rst_outs", int'({busy, ready, op_idx, cordic_mode, cordic_load, cordic_en,
                                 cordic_shift, wb_en, ang_calc}), 0);
      @(posedge clk); #1; rst = 1'b1;
      nwb = 0;
      repeat (20) begin
         tick();
         if (wb_en) nwb++;
      end
      check("t5_no_wb", nwb, 0);
      check("t5_idle", int'(busy), 0);
      start = 1'b1; issue(); tick(); start = 1'b0;
      wait_ready("t5_ready");
      ack = 1'b1; tick(); ack = 1'b0;

      // T6: ITER=4 instance
      e4 = 0; l4 = 0; s4 = 0;
      start4 = 1'b1; tick(); start4 = 1'b0;
      n = 1;
      while (!ready4 && n < 200) begin
         if (load4) begin
            l4++;
            s4 = 0;
         end
         if (en4) begin
            check("t6_shift", int'(shift4), s4);
            s4++;
            e4++;
         end
         tick();
         n++;
      end
      check("t6_latency", n - 1, LAT4);
      check("t6_n_en", e4, NOPS * ITER4);
      check("t6_n_load", l4, NOPS);
      ack4 = 1'b1; tick(); ack4 = 1'b0;
      check("t6_ack", int'(ready4), 0);

      repeat (3) tick();
      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
